// File: rtl/spi_mitm_logic_if.sv
// Bus-side signal bundle between the SPI bus control stage and the MITM engine.
// With MITM_STATS_EN defined it also carries tamper_count and last_miso.
interface spi_mitm_logic_if #(
    parameter int BUF_SIZE         = 8,
    parameter int CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1)
);
    logic                        comm_active;
    logic                        bus_ready;
    logic [BUF_SIZE-1:0]         real_miso_data;
    logic [BUF_SIZE-1:0]         real_mosi_data;
    logic                        cmd_next_chunk;
    logic                        cmd_finish;
    logic [CHUNK_SIZE_WIDTH-1:0] next_chunk_size;
    logic                        fake_miso_select;
    logic                        fake_mosi_select;
    logic [BUF_SIZE-1:0]         fake_miso_data;
    logic [BUF_SIZE-1:0]         fake_mosi_data;
    logic [BUF_SIZE-1:0]         cmd_byte;
    logic                        match;
    logic                        busy;
`ifdef MITM_STATS_EN
    logic [15:0]                 tamper_count;
    logic [BUF_SIZE-1:0]         last_miso;
`else
`endif

    modport master (
        input  comm_active, bus_ready, real_miso_data, real_mosi_data,
        output cmd_next_chunk, cmd_finish, next_chunk_size, fake_miso_select,
               fake_mosi_select, fake_miso_data, fake_mosi_data, cmd_byte,
               match, busy
`ifdef MITM_STATS_EN
        , output tamper_count, last_miso
`else
`endif
    );

    modport slave (
        output comm_active, bus_ready, real_miso_data, real_mosi_data,
        input  cmd_next_chunk, cmd_finish, next_chunk_size, fake_miso_select,
               fake_mosi_select, fake_miso_data, fake_mosi_data, cmd_byte,
               match, busy
`ifdef MITM_STATS_EN
        , input tamper_count, last_miso
`else
`endif
    );
endinterface

// File: rtl/spi_mitm_logic.sv
// MITM decision engine: walks each SPI transaction chunk by chunk and fakes MISO
// after a TARGET_CMD command byte. MITM_STATS_EN adds tamper_count/last_miso.
module spi_mitm_logic #(
    parameter int                  BUF_SIZE         = 8,
    parameter int                  CHUNK_SIZE_WIDTH = $clog2(BUF_SIZE + 1),
    parameter int                  MAX_CHUNKS       = 4,
    parameter logic [BUF_SIZE-1:0] TARGET_CMD       = 8'h9F,
    parameter logic [BUF_SIZE-1:0] FAKE_BASE        = 8'hA5
) (
    input logic              sys_clk,
    input logic              rst,
    spi_mitm_logic_if.master bus
);
    localparam int              IDX_W    = 4;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_CHUNKS);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_ACK  = 3'd2,
        WAIT_DONE = 3'd3,
        EVAL      = 3'd4,
        FINISH    = 3'd5,
        WAIT_END  = 3'd6
    } state_t;

    state_t                      state_q, state_d;
    logic [IDX_W-1:0]            chunk_idx_q, chunk_idx_d;
    logic [IDX_W-1:0]            idx_inc_s;
    logic                        cmd_next_q, cmd_next_d;
    logic                        cmd_finish_q, cmd_finish_d;
    logic                        sel_q, sel_d;
    logic [BUF_SIZE-1:0]         fake_q, fake_d;
    logic [BUF_SIZE-1:0]         cmd_byte_q, cmd_byte_d;
    logic                        match_q, match_d;
    logic                        busy_q;
    logic [CHUNK_SIZE_WIDTH-1:0] chunk_size_q;
    logic                        abort_s;
    logic                        cmd_hit_s;

    // Next-state and next-output logic; an abort overrides every other transition.
    always_comb begin
        state_d      = state_q;
        chunk_idx_d  = chunk_idx_q;
        sel_d        = sel_q;
        fake_d       = fake_q;
        cmd_byte_d   = cmd_byte_q;
        match_d      = match_q;
        cmd_next_d   = 1'b0;
        cmd_finish_d = 1'b0;
        idx_inc_s    = chunk_idx_q + 4'd1;
        cmd_hit_s    = (bus.real_mosi_data == TARGET_CMD);
        abort_s      = !bus.comm_active && (state_q != IDLE) && (state_q != WAIT_END);

        if (abort_s) begin
            state_d = IDLE;
            sel_d   = 1'b0;
            match_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sel_d   = 1'b0;
                    match_d = 1'b0;
                    if (bus.comm_active && bus.bus_ready) begin
                        chunk_idx_d = 4'd0;
                        state_d     = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ISSUE: begin
                    cmd_next_d = 1'b1;
                    state_d    = WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (!bus.bus_ready) state_d = WAIT_DONE;
                    else                state_d = WAIT_ACK;
                end
                WAIT_DONE: begin
                    if (bus.bus_ready) state_d = EVAL;
                    else               state_d = WAIT_DONE;
                end
                EVAL: begin
                    if (chunk_idx_q == 4'd0) begin
                        cmd_byte_d = bus.real_mosi_data;
                        match_d    = cmd_hit_s;
                    end else begin
                        match_d = match_q;
                    end
                    chunk_idx_d = idx_inc_s;
                    if (idx_inc_s == LAST_IDX) begin
                        state_d = FINISH;
                    end else begin
                        state_d = ISSUE;
                        sel_d   = match_d;
                        fake_d  = FAKE_BASE + BUF_SIZE'(idx_inc_s);
                    end
                end
                FINISH: begin
                    sel_d        = 1'b0;
                    cmd_finish_d = 1'b1;
                    state_d      = WAIT_END;
                end
                WAIT_END: begin
                    if (!bus.comm_active) state_d = IDLE;
                    else                  state_d = WAIT_END;
                end
                default: begin
                    state_d = IDLE;
                    sel_d   = 1'b0;
                    match_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q      <= IDLE;
            chunk_idx_q  <= 4'd0;
            cmd_next_q   <= 1'b0;
            cmd_finish_q <= 1'b0;
            sel_q        <= 1'b0;
            fake_q       <= '0;
            cmd_byte_q   <= '0;
            match_q      <= 1'b0;
            busy_q       <= 1'b0;
            chunk_size_q <= CHUNK_SIZE_WIDTH'(BUF_SIZE);
        end else begin
            state_q      <= state_d;
            chunk_idx_q  <= chunk_idx_d;
            cmd_next_q   <= cmd_next_d;
            cmd_finish_q <= cmd_finish_d;
            sel_q        <= sel_d;
            fake_q       <= fake_d;
            cmd_byte_q   <= cmd_byte_d;
            match_q      <= match_d;
            busy_q       <= (state_d != IDLE);
            chunk_size_q <= CHUNK_SIZE_WIDTH'(BUF_SIZE);
        end
    end

    assign bus.cmd_next_chunk   = cmd_next_q;
    assign bus.cmd_finish       = cmd_finish_q;
    assign bus.next_chunk_size  = chunk_size_q;
    assign bus.fake_miso_select = sel_q;
    assign bus.fake_miso_data   = fake_q;
    assign bus.fake_mosi_select = 1'b0;
    assign bus.fake_mosi_data   = '0;
    assign bus.cmd_byte         = cmd_byte_q;
    assign bus.match            = match_q;
    assign bus.busy             = busy_q;

`ifdef MITM_STATS_EN
    logic [15:0]         tamper_count_q;
    logic [BUF_SIZE-1:0] last_miso_q;

    // Count tampered transactions that reach FINISH; latch MISO on every EVAL.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            tamper_count_q <= 16'd0;
            last_miso_q    <= '0;
        end else begin
            if ((state_q == EVAL) && (state_d == FINISH) && match_d &&
                (tamper_count_q != 16'hFFFF)) begin
                tamper_count_q <= tamper_count_q + 16'd1;
            end
            if ((state_q == EVAL) && !abort_s) begin
                last_miso_q <= bus.real_miso_data;
            end
        end
    end

    assign bus.tamper_count = tamper_count_q;
    assign bus.last_miso    = last_miso_q;
`else
    logic unused_miso_s;
    assign unused_miso_s = ^bus.real_miso_data;
`endif
endmodule

// File: tb/tb_spi_mitm_logic.sv
// Scoreboard bench for spi_mitm_logic: a bus-control model drives transactions and
// queues the expected pulse contents; a negedge monitor pops and compares them.
module tb_spi_mitm_logic;
    logic sys_clk = 1'b0;
    logic rst;

    spi_mitm_logic_if #(.BUF_SIZE(8)) bus_if ();

    spi_mitm_logic #(
        .BUF_SIZE   (8),
        .MAX_CHUNKS (4),
        .TARGET_CMD (8'h9F),
        .FAKE_BASE  (8'hA5)
    ) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus_if)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic       fin;
        logic       sel;
        logic [7:0] data;
        logic       chk_data;
        logic       match;
        logic [7:0] cmd;
    } exp_t;

    exp_t       exp_q[$];
    int         n_vec    = 0;
    int         n_err    = 0;
    logic [7:0] last_cmd = 8'h00;

    function automatic void chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    task automatic push_exp(input logic fin, input logic sel, input logic [7:0] data,
                            input logic chk_data, input logic match, input logic [7:0] cmd);
        exp_t e;
        e.fin      = fin;
        e.sel      = sel;
        e.data     = data;
        e.chk_data = chk_data;
        e.match    = match;
        e.cmd      = cmd;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge sys_clk) begin
        exp_t e;
        if (!rst && (bus_if.cmd_next_chunk || bus_if.cmd_finish)) begin
            chk("pulse_exclusive", 16'(bus_if.cmd_next_chunk & bus_if.cmd_finish), 16'd0);
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: next=%0b finish=%0b, expected no pulse",
                         bus_if.cmd_next_chunk, bus_if.cmd_finish);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_kind", 16'(bus_if.cmd_finish), 16'(e.fin));
                chk("fake_miso_select", 16'(bus_if.fake_miso_select), 16'(e.sel));
                if (e.chk_data) chk("fake_miso_data", 16'(bus_if.fake_miso_data), 16'(e.data));
                chk("match", 16'(bus_if.match), 16'(e.match));
                chk("cmd_byte", 16'(bus_if.cmd_byte), 16'(e.cmd));
                chk("next_chunk_size", 16'(bus_if.next_chunk_size), 16'd8);
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_next"},       16'(bus_if.cmd_next_chunk),   16'd0);
        chk({tag, "_finish"},     16'(bus_if.cmd_finish),       16'd0);
        chk({tag, "_size"},       16'(bus_if.next_chunk_size),  16'd8);
        chk({tag, "_miso_sel"},   16'(bus_if.fake_miso_select), 16'd0);
        chk({tag, "_miso_data"},  16'(bus_if.fake_miso_data),   16'd0);
        chk({tag, "_mosi_sel"},   16'(bus_if.fake_mosi_select), 16'd0);
        chk({tag, "_mosi_data"},  16'(bus_if.fake_mosi_data),   16'd0);
        chk({tag, "_cmd_byte"},   16'(bus_if.cmd_byte),         16'd0);
        chk({tag, "_match"},      16'(bus_if.match),            16'd0);
        chk({tag, "_busy"},       16'(bus_if.busy),             16'd0);
    endtask

    // Counts cycles (sampled #1 after each edge) until the requested pulse appears.
    task automatic wait_lat(input bit fin, input int exp_lat, input string name);
        int lat;
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge sys_clk);
            #1;
            if ((fin && bus_if.cmd_finish) || (!fin && bus_if.cmd_next_chunk)) begin
                lat = i;
                break;
            end
        end
        chk(name, 16'(lat), 16'(exp_lat));
    endtask

    // One transaction; cut >= 0 aborts (or resets, if cut_rst) at data chunk `cut`.
    task automatic run_txn(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                           input logic [7:0] d3, input int low, input int cut, input bit cut_rst);
        logic [7:0] mosi [4];
        logic       m;
        mosi[0] = d0;
        mosi[1] = d1;
        mosi[2] = d2;
        mosi[3] = d3;
        m = (d0 == 8'h9F);
        @(posedge sys_clk);
        #1;
        push_exp(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, last_cmd);
        bus_if.comm_active = 1'b1;
        bus_if.bus_ready   = 1'b1;
        wait_lat(1'b0, 2, "latency_first");
        for (int j = 0; j < 4; j++) begin
            @(posedge sys_clk);
            #1;
            bus_if.bus_ready      = 1'b0;
            bus_if.real_mosi_data = mosi[j];
            if (j == cut && !cut_rst) begin
                @(posedge sys_clk);
                #1;
                bus_if.comm_active = 1'b0;
                @(posedge sys_clk);
                #1;
                chk("abort_busy",     16'(bus_if.busy),             16'd0);
                chk("abort_select",   16'(bus_if.fake_miso_select), 16'd0);
                chk("abort_match",    16'(bus_if.match),            16'd0);
                chk("abort_cmd_byte", 16'(bus_if.cmd_byte),         16'(last_cmd));
                bus_if.bus_ready = 1'b1;
                repeat (6) @(posedge sys_clk);
                #1;
                chk("abort_stays_idle", 16'(bus_if.busy), 16'd0);
                return;
            end
            repeat (low) @(posedge sys_clk);
            #1;
            if (j == cut && cut_rst) begin
                bus_if.bus_ready = 1'b1;
                @(posedge sys_clk);
                #1;
                rst = 1'b1;
                @(posedge sys_clk);
                #1;
                check_reset("rst_in_eval");
                bus_if.comm_active = 1'b0;
                rst      = 1'b0;
                last_cmd = 8'h00;
                return;
            end
            if (j == 0) last_cmd = d0;
            if (j < 3) push_exp(1'b0, m, 8'hA5 + 8'(j + 1), 1'b1, m, d0);
            else       push_exp(1'b1, 1'b0, 8'h00, 1'b0, m, d0);
            bus_if.bus_ready = 1'b1;
            wait_lat(j == 3, 3, "latency_after_ready");
        end
        @(posedge sys_clk);
        #1;
        bus_if.comm_active = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("end_busy",     16'(bus_if.busy),     16'd0);
        chk("end_match",    16'(bus_if.match),    16'd0);
        chk("end_cmd_byte", 16'(bus_if.cmd_byte), 16'(d0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst                   = 1'b1;
        bus_if.comm_active    = 1'b0;
        bus_if.bus_ready      = 1'b1;
        bus_if.real_mosi_data = 8'h00;
        bus_if.real_miso_data = 8'h5C;
        repeat (3) @(posedge sys_clk);
        #1;
        check_reset("reset");
`ifdef MITM_STATS_EN
        chk("reset_tamper_count", bus_if.tamper_count, 16'd0);
        chk("reset_last_miso", 16'(bus_if.last_miso), 16'd0);
`else
`endif
        rst = 1'b0;

        run_txn(8'h03, 8'h11, 8'h22, 8'h33, 1, -1, 1'b0);
        run_txn(8'h9F, 8'h01, 8'h02, 8'h03, 2, -1, 1'b0);
        run_txn(8'h9F, 8'h44, 8'h55, 8'h66, 1, 2, 1'b0);
        run_txn(8'h9F, 8'h12, 8'h34, 8'h56, 20, -1, 1'b0);
`ifdef MITM_STATS_EN
        chk("tamper_count", bus_if.tamper_count, 16'd2);
        chk("last_miso", 16'(bus_if.last_miso), 16'h005C);
`else
`endif
        run_txn(8'h9F, 8'hAA, 8'hBB, 8'hCC, 1, 1, 1'b1);
`ifdef MITM_STATS_EN
        chk("tamper_after_rst", bus_if.tamper_count, 16'd0);
`else
`endif
        run_txn(8'h5A, 8'h00, 8'hFF, 8'h9F, 1, -1, 1'b0);

        repeat (3) @(posedge sys_clk);
        #1;
        chk("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
